obi_arbiter: RTL

Two-to-one OBI arbiter sharing the single memory port between the instruction-fetch requester and the load/store (data) requester. It sits between the core-side OBI controllers and the memory, with zero-latency address-phase pass-through. Arbitration is round-robin with request locking. An outstanding-transaction ID FIFO routes each response phase back to the requester that issued it.

---
 rtl/obi_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/obi_arbiter.sv
// Two-to-one OBI arbiter: instruction fetch and load/store share one memory port.
// Round-robin with request locking; an ID FIFO routes each response back to its issuer.
module obi_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    src_e             sel;
    src_e             head_id;
    src_e             last_grant_q, last_grant_d;
    src_e             lock_src_q, lock_src_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q;

    logic any_req;
    logic full;
    logic accept;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A held lock wins; otherwise a lone requester, otherwise whoever was not served last.
    always_comb begin
        sel = (last_grant_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
        if (locked_q) begin
            sel = lock_src_q;
        end else if (instr_req_i && !data_req_i) begin
            sel = SRC_INSTR;
        end else if (data_req_i && !instr_req_i) begin
            sel = SRC_DATA;
        end
    end

    assign any_req   = instr_req_i | data_req_i;
    assign full      = (count_q == MAX_CNT);
    assign mem_req_o = any_req & ~full & rst_n;
    assign accept    = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & (count_q != '0);
    assign head_id   = src_e'(fifo_q[rd_ptr_q]);

    assign instr_gnt_o = accept & (sel == SRC_INSTR);
    assign data_gnt_o  = accept & (sel == SRC_DATA);

    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = '1;
        mem_wdata_o = '0;
        if (sel == SRC_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign instr_rvalid_o = pop & (head_id == SRC_INSTR);
    assign data_rvalid_o  = pop & (head_id == SRC_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_grant_d = last_grant_q;
        locked_d     = locked_q;
        lock_src_d   = lock_src_q;

        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);

        // A stalled request pins the selection so the address phase stays stable.
        if (accept) begin
            last_grant_d = sel;
            locked_d     = 1'b0;
        end else if (mem_req_o) begin
            locked_d   = 1'b1;
            lock_src_d = sel;
        end else if (!any_req) begin
            locked_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_grant_q <= SRC_INSTR;
            locked_q     <= 1'b0;
            lock_src_q   <= SRC_INSTR;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_grant_q <= last_grant_d;
            locked_q     <= locked_d;
            lock_src_q   <= lock_src_d;
        end
    end

    // NOTE: ID storage is not reset; an entry is only read after it was written, gated by count.
    always_ff @(posedge clk) begin
        if (accept) fifo_q[wr_ptr_q] <= sel;
    end

endmodule
